// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, default
// latencies and the sequencer state type, also used by the decoder and hazard unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Signal bundle between the issue stage and the multiply/divide unit.
// Handshake: Start is a one-cycle request qualifying Op/D1/D2; it is only honoured
// while Busy is 0, so the issuer must hold HI/LO instructions while (Busy | Start).
interface mult_div_unit_if;
  logic [31:0] D1;
  logic [31:0] D2;
  logic [2:0]  Op;
  logic        Start;
  logic        HiSel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  modport master (output D1, D2, Op, Start, HiSel, input Busy, HI, LO, Out);
  modport slave  (input D1, D2, Op, Start, HiSel, output Busy, HI, LO, Out);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style HI/LO unit: the result is computed at issue, held for a
// fixed latency while Busy is high, then committed to HI/LO in one step.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [2:0]  Op,
  input  logic        Start,
  input  logic        HiSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out,
  output mdu_state_e  o_dbg_state
);

  localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  mdu_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_commit;
  logic [63:0]   r_hold;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic [63:0] w_a_s, w_b_s, w_a_u, w_b_u;
  logic [63:0] w_prod_s, w_prod_u;
  logic [63:0] w_quo_s, w_rem_s, w_quo_u, w_rem_u;
  logic [31:0] w_div_b;
  logic        w_unused;

  // A zero divisor is replaced by 1 so the quotient stays defined; that result
  // is never committed.
  assign w_div_b  = (D2 == 32'd0) ? 32'd1 : D2;
  assign w_a_s    = {{32{D1[31]}}, D1};
  assign w_b_s    = {{32{D2[31]}}, D2};
  assign w_a_u    = {32'd0, D1};
  assign w_b_u    = {32'd0, D2};
  assign w_prod_s = $signed(w_a_s) * $signed(w_b_s);
  assign w_prod_u = w_a_u * w_b_u;
  assign w_quo_s  = $signed(w_a_s) / $signed({{32{w_div_b[31]}}, w_div_b});
  assign w_rem_s  = $signed(w_a_s) % $signed({{32{w_div_b[31]}}, w_div_b});
  assign w_quo_u  = w_a_u / {32'd0, w_div_b};
  assign w_rem_u  = w_a_u % {32'd0, w_div_b};
  assign w_unused = ^{w_quo_s[63:32], w_rem_s[63:32], w_quo_u[63:32], w_rem_u[63:32]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_commit <= 1'b0;
      r_hold   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            case (Op)
              OP_MULT, OP_MULTU: begin
                r_hold   <= (Op == OP_MULT) ? w_prod_s : w_prod_u;
                r_commit <= 1'b1;
                r_cnt    <= MULT_N;
                r_busy   <= 1'b1;
                r_state  <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                r_hold   <= (Op == OP_DIV) ? {w_rem_s[31:0], w_quo_s[31:0]}
                                           : {w_rem_u[31:0], w_quo_u[31:0]};
                r_commit <= (D2 != 32'd0);
                r_cnt    <= DIV_N;
                r_busy   <= 1'b1;
                r_state  <= ST_RUN;
              end
              OP_MTHI: r_hi <= D1;
              OP_MTLO: r_lo <= D1;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // Start is deliberately not looked at here: requests during RUN are dropped.
          if (r_cnt == CW'(1)) begin
            if (r_commit) begin
              r_hi <= r_hold[63:32];
              r_lo <= r_hold[31:0];
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign Busy        = r_busy;
  assign HI          = r_hi;
  assign LO          = r_lo;
  assign Out         = HiSel ? r_hi : r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// checked against an arithmetic model of HI/LO and the busy latency.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  mdu_state_e dbg_state;

  int n_tests;
  int n_fail;

  logic [31:0] m_hi, m_lo;
  logic [31:0] exp_q[$];

  mult_div_unit_if mif ();

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .D1         (mif.D1),
    .D2         (mif.D2),
    .Op         (mif.Op),
    .Start      (mif.Start),
    .HiSel      (mif.HiSel),
    .Busy       (mif.Busy),
    .HI         (mif.HI),
    .LO         (mif.LO),
    .Out        (mif.Out),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int n, output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    n  = 0;
    hi = m_hi;
    lo = m_lo;
    case (op)
      3'd0: begin p = sa * sb; n = MC; hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = ua * ub; n = MC; hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin
        n = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      end
      3'd3: begin
        n = DC;
        if (b != 0) begin q = ua / ub; r = ua % ub; hi = r[31:0]; lo = q[31:0]; end
      end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  // ---------------- driver ----------------
  // inj_at >= 0 fires a MULT request at that busy cycle (0-based), which must be ignored.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int inj_at);
    int n, cycles;
    logic [31:0] ehi, elo, hisel_exp;
    model(op, a, b, n, ehi, elo);
    exp_q.push_back(ehi);
    exp_q.push_back(elo);
    @(negedge clk);
    mif.Op = op; mif.D1 = a; mif.D2 = b; mif.Start = 1'b1;
    @(negedge clk);
    mif.Start = 1'b0;
    mif.D1 = $urandom; mif.D2 = $urandom; mif.Op = 3'($urandom_range(0, 7));
    cycles = 0;
    while (mif.Busy && cycles < 64) begin
      if (cycles == 1) begin
        check_val({tag, "_hi_hold"}, mif.HI, m_hi);
        check_val({tag, "_lo_hold"}, mif.LO, m_lo);
      end
      if (cycles == inj_at) begin
        mif.Op = 3'd0; mif.D1 = 32'h0000_0007; mif.D2 = 32'h0000_0009; mif.Start = 1'b1;
      end
      @(negedge clk);
      mif.Start = 1'b0;
      cycles++;
    end
    check_val({tag, "_busy_cycles"}, 32'(cycles), 32'(n));
    ehi = exp_q.pop_front();
    elo = exp_q.pop_front();
    check_val({tag, "_hi"}, mif.HI, ehi);
    check_val({tag, "_lo"}, mif.LO, elo);
    mif.HiSel = 1'($urandom_range(0, 1));
    hisel_exp = mif.HiSel ? ehi : elo;
    #1;
    check_val({tag, "_out"}, mif.Out, hisel_exp);
    m_hi = ehi;
    m_lo = elo;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    n_tests = 0; n_fail = 0;
    m_hi = '0; m_lo = '0;
    mif.D1 = '0; mif.D2 = '0; mif.Op = '0; mif.Start = 1'b0; mif.HiSel = 1'b0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    check_val("rst_busy", {31'd0, mif.Busy}, 32'd0);
    check_val("rst_hi", mif.HI, 32'd0);
    check_val("rst_lo", mif.LO, 32'd0);
    check_val("rst_out", mif.Out, 32'd0);
    check_val("rst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_op("mult",     3'd0, 32'hFFFF_FFFE, 32'd3, -1);
    check_val("mult_const_hi", m_hi, 32'hFFFF_FFFF);
    check_val("mult_const_lo", m_lo, 32'hFFFF_FFFA);
    do_op("multu",    3'd1, 32'hFFFF_FFFE, 32'd3, -1);
    check_val("multu_const_hi", m_hi, 32'h0000_0002);
    do_op("div_neg",  3'd2, 32'hFFFF_FFF9, 32'd2, -1);
    check_val("div_const_lo", m_lo, 32'hFFFF_FFFD);
    check_val("div_const_hi", m_hi, 32'hFFFF_FFFF);
    do_op("divu_by0", 3'd3, 32'h1234_0000, 32'd0, -1);
    do_op("div_by0",  3'd2, 32'h0000_0055, 32'd0, -1);
    do_op("div_inj",  3'd2, 32'd1000, 32'hFFFF_FFF3, 2);
    do_op("mtlo",     3'd5, 32'h1234_5678, 32'd0, -1);
    mif.HiSel = 1'b0; #1;
    check_val("mtlo_out", mif.Out, 32'h1234_5678);
    do_op("mthi",     3'd4, 32'hCAFE_F00D, 32'd0, -1);
    do_op("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check_val("div_ovf_const_lo", m_lo, 32'h8000_0000);
    check_val("div_ovf_const_hi", m_hi, 32'h0000_0000);
    do_op("undef6",   3'd6, 32'h1111_1111, 32'd5, -1);
    do_op("undef7",   3'd7, 32'h2222_2222, 32'd5, -1);

    // Reset in the middle of a MULT: clears at once, nothing commits later.
    do_op("pre_rst", 3'd4, 32'hA5A5_A5A5, 32'd0, -1);
    @(negedge clk);
    mif.Op = 3'd0; mif.D1 = 32'd123; mif.D2 = 32'd456; mif.Start = 1'b1;
    @(negedge clk);
    mif.Start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("midrst_busy", {31'd0, mif.Busy}, 32'd0);
    check_val("midrst_hi", mif.HI, 32'd0);
    check_val("midrst_lo", mif.LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    cyc = 0;
    repeat (8) begin
      @(negedge clk);
      if (mif.Busy) cyc++;
    end
    check_val("postrst_busy_seen", 32'(cyc), 32'd0);
    check_val("postrst_hi", mif.HI, 32'd0);
    check_val("postrst_lo", mif.LO, 32'd0);

    // First request right after reset release is accepted.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mif.Op = 3'd4; mif.D1 = 32'h0BAD_BEEF; mif.Start = 1'b1;
    @(negedge clk);
    mif.Start = 1'b0;
    check_val("first_start_hi", mif.HI, 32'h0BAD_BEEF);
    m_hi = 32'h0BAD_BEEF;

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      do_op("rand", op, rand_operand(), rand_operand(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL provide port clk, input, 1: sole clock; all state changes on posedge.
REQ-004 SHALL provide port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL provide port D1, input, 32: operand A, the forwarded GRF RD1 value.
REQ-006 SHALL provide port D2, input, 32: operand B, the forwarded GRF RD2 value.
REQ-007 SHALL provide port Op, input, 3: operation, one of MULT, MULTU, DIV, DIVU, MTHI or MTLO.
REQ-008 SHALL provide port Start, input, 1: one-cycle request qualifying Op.
REQ-009 SHALL provide port HiSel, input, 1: Out selects HI when 1, LO when 0.
REQ-010 SHALL provide port Busy, output, 1: a multiply/divide is in progress.
REQ-011 SHALL provide port HI, output, 32: architectural HI register.
REQ-012 SHALL provide port LO, output, 32: architectural LO register.
REQ-013 SHALL provide port Out, output, 32: combinational HiSel ? HI : LO (MFHI/MFLO path toward writeback/GRF WD).

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and RUN, plus a cycle counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 SHALL sample Start only in IDLE; Start in RUN SHALL be ignored, with no change to state, counter or result.
REQ-016 On a Start edge in IDLE with MULT/MULTU/DIV/DIVU: capture the 64-bit result into holding registers, load the counter with N (MULT_CYCLES or DIV_CYCLES), and enter RUN.
REQ-017 Busy SHALL be 1 exactly while the FSM is in RUN, i.e. for N cycles after the Start edge.
REQ-018 At the Nth edge after Start, HI/LO SHALL take the held result and the FSM SHALL return to IDLE; HI/LO SHALL be unchanged before that edge.
REQ-019 MULT SHALL produce the signed 32x32 product and MULTU the unsigned product; {HI,LO} = 64-bit product.
REQ-020 DIV SHALL produce signed results: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend; DIVU SHALL do the same unsigned.
REQ-021 DIV/DIVU with D2 == 0 SHALL still run DIV_CYCLES with Busy high and SHALL leave HI/LO unchanged at completion.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.
REQ-023 MTHI/MTLO with Start in IDLE SHALL write D1 into HI/LO at that edge, with zero latency and Busy staying 0.
REQ-024 MTHI/MTLO in RUN SHALL be ignored; the upstream hazard unit stalls on (Busy | Start) for any HI/LO instruction.
REQ-025 Out SHALL reflect HI/LO as committed, with no bypass of the in-flight result.
REQ-026 Undefined Op codes with Start SHALL be treated as no operation.

Reset
REQ-027 reset low SHALL immediately force FSM = IDLE, counter = 0, Busy = 0, HI = 0, LO = 0 and holding registers = 0, regardless of clk.
REQ-028 reset asserted mid-operation SHALL abort the operation with no later HI/LO update.
REQ-029 The first Start SHALL be accepted on the first posedge after reset deasserts.

Structure
REQ-030 Op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5) and the default cycle counts SHALL live in the shared package mdu_pkg, also used by the decoder and hazard unit.
REQ-031 The block SHALL be a single module with no sub-module; arithmetic SHALL be behavioural operators on 64-bit sign- or zero-extended operands.

Verification
REQ-032 MULT, D1=0xFFFFFFFE, D2=3, Start -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 MULTU, same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
REQ-034 DIV, D1=0xFFFFFFF9 (-7), D2=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with D2=0 -> HI/LO unchanged after 10 busy cycles.
REQ-035 DIV running, Start with MULT on cycle 3 -> ignored; DIV completes at cycle 10 with the correct result, then Busy=0.
REQ-036 MTLO, D1=0x12345678 -> LO=0x12345678 at the next edge, Busy never rises; HiSel=0 -> Out=0x12345678.
REQ-037 MULT started, reset pulled low at cycle 2 -> Busy=0, HI=LO=0 immediately; no update after reset releases.
